// File: rtl/command_issue_control.sv
// Command issue stage: buffers arbiter lines in a FIFO and issues them under PSL credit control.
// Optional issue/stall statistics are compiled in with `define CMD_ISSUE_STATS_EN.
module command_issue_control #(
    parameter int BUFFER_DEPTH       = 16,
    parameter int ALMOST_FULL_MARGIN = 2,
    parameter int TAG_WIDTH          = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enabled_in,
    input  logic [7:0]           ha_croom,
    input  logic                 command_arbiter_in_valid,
    input  logic [7:0]           command_arbiter_in_cmd,
    input  logic [12:0]          command_arbiter_in_command,
    input  logic [63:0]          command_arbiter_in_address,
    input  logic [11:0]          command_arbiter_in_size,
    input  logic [2:0]           command_arbiter_in_abt,
    input  logic                 response_valid,
    output logic                 command_out_valid,
    output logic [7:0]           command_out_cmd,
    output logic [12:0]          command_out_command,
    output logic [63:0]          command_out_address,
    output logic [11:0]          command_out_size,
    output logic [2:0]           command_out_abt,
    output logic [TAG_WIDTH-1:0] cmd_tag,
    output logic                 buffer_almost_full,
    output logic                 buffer_empty,
    output logic [7:0]           credits_out,
    output logic                 overflow_error
`ifdef CMD_ISSUE_STATS_EN
    ,
    output logic [31:0]          issued_count,
    output logic [31:0]          stall_count
`endif
);

    localparam int          AW          = $clog2(BUFFER_DEPTH);
    localparam int          LINE_W      = 100;
    localparam logic [12:0] CMD_INVALID = 13'h0000;
    localparam logic [2:0]  ABT_STRICT  = 3'b000;
    localparam logic [AW:0] AF_LEVEL    = (AW+1)'(BUFFER_DEPTH - ALMOST_FULL_MARGIN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_enabled;
    logic                w_load;
    logic                w_run;
    logic                w_active;

    logic [LINE_W-1:0]   r_mem [BUFFER_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [AW:0]         w_wr_ptr_nxt;
    logic [AW:0]         w_rd_ptr_nxt;
    logic [AW:0]         w_count_nxt;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_resp;
    logic [LINE_W-1:0]   w_in_line;

    logic [7:0]          r_credits;
    logic [7:0]          r_credit_max;
    logic [7:0]          w_credits_nxt;
    logic [TAG_WIDTH-1:0] r_tag_cnt;
    logic [TAG_WIDTH-1:0] r_cmd_tag;
    logic                r_out_valid;
    logic [LINE_W-1:0]   r_out_line;
    logic                r_almost_full;
    logic                r_empty;
    logic                r_overflow;

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_enabled <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_enabled <= enabled_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_enabled) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_RUN;
            S_RUN:   if (!r_enabled) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (r_enabled)
                    w_state_nxt = S_RUN;
                else if (w_empty && !r_out_valid)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == S_LOAD);
        w_run    = (r_state == S_RUN);
        w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    end

    // ---------------- FIFO pointers and flags ----------------
    assign w_in_line = {command_arbiter_in_cmd, command_arbiter_in_command,
                        command_arbiter_in_address, command_arbiter_in_size,
                        command_arbiter_in_abt};

    // The extra MSB on each pointer separates full from empty when the indices match.
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push       = w_run && command_arbiter_in_valid && !w_full;
    assign w_pop        = w_active && !w_empty && (r_credits != 8'd0);
    assign w_resp       = w_active && response_valid;
    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= w_in_line;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_almost_full <= 1'b0;
            r_empty       <= 1'b1;
            r_overflow    <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_almost_full <= (w_count_nxt >= AF_LEVEL);
            r_empty       <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            if (w_run && command_arbiter_in_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    // ---------------- credits ----------------
    // A response arriving together with an issue cancels out, even at credit_max.
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_load)
            w_credits_nxt = ha_croom;
        else if (w_pop && !w_resp)
            w_credits_nxt = r_credits - 8'd1;
        else if (w_resp && !w_pop && (r_credits < r_credit_max))
            w_credits_nxt = r_credits + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_credits    <= 8'd0;
            r_credit_max <= 8'd0;
        end else begin
            r_credits <= w_credits_nxt;
            if (w_load)
                r_credit_max <= ha_croom;
        end
    end

    // ---------------- issue register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_line  <= {8'h00, CMD_INVALID, 64'h0, 12'h000, ABT_STRICT};
            r_cmd_tag   <= '0;
            r_tag_cnt   <= '0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_out_line <= r_mem[r_rd_ptr[AW-1:0]];
                r_cmd_tag  <= r_tag_cnt;
                r_tag_cnt  <= r_tag_cnt + TAG_WIDTH'(1);
            end
        end
    end

    assign command_out_valid   = r_out_valid;
    assign {command_out_cmd, command_out_command, command_out_address,
            command_out_size, command_out_abt} = r_out_line;
    assign cmd_tag             = r_cmd_tag;
    assign buffer_almost_full  = r_almost_full;
    assign buffer_empty        = r_empty;
    assign credits_out         = r_credits;
    assign overflow_error      = r_overflow;

`ifdef CMD_ISSUE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_issued_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_issued_count <= 32'd0;
            r_stall_count  <= 32'd0;
        end else begin
            if (w_pop)
                r_issued_count <= sat_inc(r_issued_count);
            if (w_active && !w_empty && (r_credits == 8'd0))
                r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign issued_count = r_issued_count;
    assign stall_count  = r_stall_count;
`endif

endmodule

// File: tb/tb_command_issue_control.sv
// Bench for command_issue_control: queue-based reference model driven by randomized command traffic.
module tb_command_issue_control;

    logic         clock = 1'b0;
    logic         reset;
    logic         enabled_in;
    logic [7:0]   ha_croom;
    logic         in_valid;
    logic [7:0]   in_cmd;
    logic [12:0]  in_command;
    logic [63:0]  in_address;
    logic [11:0]  in_size;
    logic [2:0]   in_abt;
    logic         response_valid;
    logic         out_valid;
    logic [7:0]   out_cmd;
    logic [12:0]  out_command;
    logic [63:0]  out_address;
    logic [11:0]  out_size;
    logic [2:0]   out_abt;
    logic [7:0]   cmd_tag;
    logic         buffer_almost_full;
    logic         buffer_empty;
    logic [7:0]   credits_out;
    logic         overflow_error;
`ifdef CMD_ISSUE_STATS_EN
    logic [31:0]  issued_count;
    logic [31:0]  stall_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    command_issue_control dut (
        .clock                      (clock),
        .reset                      (reset),
        .enabled_in                 (enabled_in),
        .ha_croom                   (ha_croom),
        .command_arbiter_in_valid   (in_valid),
        .command_arbiter_in_cmd     (in_cmd),
        .command_arbiter_in_command (in_command),
        .command_arbiter_in_address (in_address),
        .command_arbiter_in_size    (in_size),
        .command_arbiter_in_abt     (in_abt),
        .response_valid             (response_valid),
        .command_out_valid          (out_valid),
        .command_out_cmd            (out_cmd),
        .command_out_command        (out_command),
        .command_out_address        (out_address),
        .command_out_size           (out_size),
        .command_out_abt            (out_abt),
        .cmd_tag                    (cmd_tag),
        .buffer_almost_full         (buffer_almost_full),
        .buffer_empty               (buffer_empty),
        .credits_out                (credits_out),
        .overflow_error             (overflow_error)
`ifdef CMD_ISSUE_STATS_EN
        ,
        .issued_count               (issued_count),
        .stall_count                (stall_count)
`endif
    );

    // Reference model: a queue of pending lines plus credit/tag bookkeeping.
    // Phase: 0 idle, 1 load, 2 run, 3 drain.
    logic [99:0] q[$];
    int          m_phase;
    bit          m_en_r;
    int          m_credits;
    int          m_cmax;
    int          m_tag;
    logic [99:0] m_line;
    bit          m_oval;
    int          m_otag;
    bit          m_ovf;
    longint      m_issued;
    longint      m_stall;

    function automatic void model_reset();
        q.delete();
        m_phase = 0; m_en_r = 0; m_credits = 0; m_cmax = 0; m_tag = 0;
        m_line = '0; m_oval = 0; m_otag = 0; m_ovf = 0; m_issued = 0; m_stall = 0;
    endfunction

    function automatic void model_update();
        int sz;
        bit act, iss, resp, prev_oval;
        sz        = q.size();
        act       = (m_phase == 2) || (m_phase == 3);
        iss       = act && (sz > 0) && (m_credits > 0);
        resp      = act && response_valid;
        prev_oval = m_oval;
        if (act && sz > 0 && m_credits == 0) m_stall++;
        if (iss) begin
            m_line = q.pop_front();
            m_oval = 1;
            m_otag = m_tag;
            m_tag  = (m_tag + 1) % 256;
            m_issued++;
        end else begin
            m_oval = 0;
        end
        if (m_phase == 2 && in_valid) begin
            if (sz == 16) m_ovf = 1;
            else q.push_back({in_cmd, in_command, in_address, in_size, in_abt});
        end
        if (m_phase == 1) begin
            m_credits = ha_croom;
            m_cmax    = ha_croom;
        end else if (iss && !resp) begin
            m_credits--;
        end else if (resp && !iss && m_credits < m_cmax) begin
            m_credits++;
        end
        case (m_phase)
            0: if (m_en_r) m_phase = 1;
            1: m_phase = 2;
            2: if (!m_en_r) m_phase = 3;
            default: begin
                if (m_en_r) m_phase = 2;
                else if (sz == 0 && !prev_oval) m_phase = 0;
            end
        endcase
        m_en_r = enabled_in;
    endfunction

    function automatic logic [119:0] exp_vec();
        return {m_oval, m_line, 8'(m_otag), (q.size() >= 14), (q.size() == 0),
                8'(m_credits), m_ovf};
    endfunction

    function automatic logic [119:0] dut_vec();
        return {out_valid, out_cmd, out_command, out_address, out_size, out_abt,
                cmd_tag, buffer_almost_full, buffer_empty, credits_out, overflow_error};
    endfunction

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drive_cmd(input bit v);
        in_valid   = v;
        in_cmd     = 8'($urandom);
        in_command = 13'($urandom);
        in_address = {$urandom, $urandom};
        in_size    = 12'($urandom);
        in_abt     = 3'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enabled_in = 0; ha_croom = 0; response_valid = 0;
        drive_cmd(0);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_cmd, out_command, out_address, out_size, out_abt, cmd_tag} !== '0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b cmd=%h command=%h tag=%h, want all zero",
                     out_valid, out_cmd, out_command, cmd_tag);
        end
        checks++;
        if ({buffer_almost_full, buffer_empty, credits_out, overflow_error} !== 11'b01_0000_0000_0) begin
            errors++;
            $display("FAIL reset_flags: got afull=%b empty=%b credits=%0d ovf=%b, want 0 1 0 0",
                     buffer_almost_full, buffer_empty, credits_out, overflow_error);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_load();
        enabled_in = 1; ha_croom = 8'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL load_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (credits_out !== 8'd4 || out_valid !== 1'b0 || buffer_empty !== 1'b1) begin
            errors++;
            $display("FAIL load_credits: got credits=%0d valid=%b empty=%b, want 4 0 1",
                     credits_out, out_valid, buffer_empty);
        end
    endtask

    task automatic test_back_to_back();
        int tags[$];
        for (int i = 0; i < 10; i++) begin
            drive_cmd(i < 6);
            step();
            if (out_valid) tags.push_back(int'(cmd_tag));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (tags.size() != 4 || tags[0] != 0 || tags[1] != 1 || tags[2] != 2 || tags[3] != 3) begin
            errors++;
            $display("FAIL b2b_tags: got %0d issues %p, want tags 0,1,2,3", tags.size(), tags);
        end
        checks++;
        if (credits_out !== 8'd0 || buffer_empty !== 1'b0 || q.size() != 2) begin
            errors++;
            $display("FAIL b2b_hold: got credits=%0d empty=%b, want 0 0 (2 held)",
                     credits_out, buffer_empty);
        end
`ifdef CMD_ISSUE_STATS_EN
        checks++;
        if (stall_count < 32'd1 || stall_count !== 32'(m_stall)) begin
            errors++;
            $display("FAIL b2b_stall: got %0d want %0d (>=1)", stall_count, m_stall);
        end
`endif
    endtask

    task automatic test_response_return();
        int tags[$];
        bit pulses[6] = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            response_valid = pulses[i];
            step();
            if (out_valid) tags.push_back(int'(cmd_tag));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resp_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        response_valid = 0;
        checks++;
        if (tags.size() != 2 || tags[0] != 4 || tags[1] != 5) begin
            errors++;
            $display("FAIL resp_tags: got %p, want 4,5", tags);
        end
        checks++;
        if (credits_out !== 8'd0 || buffer_empty !== 1'b1) begin
            errors++;
            $display("FAIL resp_end: got credits=%0d empty=%b, want 0 1", credits_out, buffer_empty);
        end
    endtask

    task automatic test_full_overflow();
        enabled_in = 1; ha_croom = 8'd0;
        drive_cmd(0);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        for (int k = 1; k <= 17; k++) begin
            drive_cmd(1);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_wr%0d: got %h want %h", k, dut_vec(), exp_vec());
            end
            if (k == 13 || k == 14) begin
                checks++;
                if (buffer_almost_full !== (k == 14)) begin
                    errors++;
                    $display("FAIL afull_at_%0d: got %b want %b", k, buffer_almost_full, k == 14);
                end
            end
            if (k == 16 || k == 17) begin
                checks++;
                if (overflow_error !== (k == 17)) begin
                    errors++;
                    $display("FAIL ovf_at_%0d: got %b want %b", k, overflow_error, k == 17);
                end
            end
        end
        drive_cmd(0);
        step();
        checks++;
        if (overflow_error !== 1'b1 || q.size() != 16 || buffer_almost_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b afull=%b, want 1 1 (occupancy 16)",
                     overflow_error, buffer_almost_full);
        end
    endtask

    task automatic test_credit_balance();
        enabled_in = 1; ha_croom = 8'd3; response_valid = 0;
        drive_cmd(0);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        drive_cmd(1);
        step();
        drive_cmd(0);
        response_valid = 1;
        step();
        checks++;
        if (credits_out !== 8'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL credit_both: got credits=%0d valid=%b, want 3 1", credits_out, out_valid);
        end
        step();
        checks++;
        if (credits_out !== 8'd3) begin
            errors++;
            $display("FAIL credit_sat: got %0d want 3", credits_out);
        end
        response_valid = 0;
        drive_cmd(1);
        step();
        drive_cmd(0);
        step();
        checks++;
        if (credits_out !== 8'd2 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL credit_dec: got %h want %h (credits 2)", dut_vec(), exp_vec());
        end
        response_valid = 1;
        step();
        response_valid = 0;
        checks++;
        if (credits_out !== 8'd3) begin
            errors++;
            $display("FAIL credit_inc: got %0d want 3", credits_out);
        end
    endtask

    task automatic test_drain();
        int issued;
        enabled_in = 1; ha_croom = 8'd8; response_valid = 0;
        drive_cmd(0);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cmd(i < 3 || i > 3);
            enabled_in = (i < 2);
            step();
            if (out_valid) issued++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        drive_cmd(0);
        checks++;
        if (issued != 3 || buffer_empty !== 1'b1 || credits_out !== 8'd5) begin
            errors++;
            $display("FAIL drain_count: got issued=%0d empty=%b credits=%0d, want 3 1 5",
                     issued, buffer_empty, credits_out);
        end
        response_valid = 1;
        step();
        response_valid = 0;
        checks++;
        if (credits_out !== 8'd5) begin
            errors++;
            $display("FAIL idle_resp: got credits=%0d want 5", credits_out);
        end
        enabled_in = 1;
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1);
            enabled_in = 0;
            step();
        end
        drive_cmd(0);
        step();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({out_valid, cmd_tag, buffer_almost_full, buffer_empty, credits_out, overflow_error,
             out_cmd, out_command, out_address} !== {1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 85'd0}) begin
            errors++;
            $display("FAIL reset_mid_drain: got valid=%b tag=%0d empty=%b credits=%0d, want 0 0 1 0",
                     out_valid, cmd_tag, buffer_empty, credits_out);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_tag_wrap();
        int tags[$];
        enabled_in = 1; ha_croom = 8'd255; response_valid = 0;
        drive_cmd(0);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        response_valid = 1;
        for (int i = 0; i < 262; i++) begin
            drive_cmd(i < 257);
            step();
            if (out_valid) tags.push_back(int'(cmd_tag));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        response_valid = 0;
        drive_cmd(0);
        checks++;
        if (tags.size() != 257 || tags[255] != 255 || tags[256] != 0) begin
            errors++;
            $display("FAIL tag_wrap: got %0d issues, tag255=%0d tag256=%0d, want 257 255 0",
                     tags.size(), tags.size() > 255 ? tags[255] : -1,
                     tags.size() > 256 ? tags[256] : -1);
        end
    endtask

    task automatic test_random();
        enabled_in = 1; ha_croom = 8'($urandom_range(0, 6)); response_valid = 0;
        drive_cmd(0);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) enabled_in = ~enabled_in;
            if ($urandom_range(0, 9) == 0) ha_croom = 8'($urandom_range(0, 6));
            drive_cmd($urandom_range(0, 1) == 1);
            response_valid = ($urandom_range(0, 9) < 3);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        response_valid = 0;
        drive_cmd(0);
`ifdef CMD_ISSUE_STATS_EN
        checks++;
        if (issued_count !== 32'(m_issued) || stall_count !== 32'(m_stall)) begin
            errors++;
            $display("FAIL rand_stats: got issued=%0d stall=%0d want %0d %0d",
                     issued_count, stall_count, m_issued, m_stall);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_response_return();
        test_full_overflow();
        test_credit_balance();
        test_drain();
        test_tag_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
